// File: rtl/perf_window_ctrl.sv
// perf_window_ctrl: drives start/stop of an external cycle counter around DUT begin/end
// events and accumulates last/min/max/sum/count/timeout statistics behind a read port.
module perf_window_ctrl #(
  parameter int SUM_W = 48,
  parameter logic [31:0] TIMEOUT = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic        clr_stats,
  input  logic        ev_begin,
  input  logic        ev_end,
  output logic        pc_start,
  output logic        pc_stop,
  input  logic [31:0] pc_value,
  input  logic        rd_en,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        sample_done
);
  typedef enum logic [2:0] {IDLE, ARMED, START, RUN, STOP, SAMPLE} state_t;
  state_t state_q;
  logic mode_q, abort_pend_q, tmo_q, terr_q, done_q, rd_valid_q;
  logic [31:0] rc_q, last_q, min_q, max_q, cnt_q, tmo_cnt_q, rd_data_q;
  logic [SUM_W-1:0] sum_q, sum_b, sum_d;
  logic [SUM_W-33:0] shadow_q;
  logic [SUM_W:0] sum_x;
  logic [31:0] last_d, min_b, min_d, max_b, max_d, cnt_b, cnt_d, tmo_b, tmo_d, rd_d;
  logic arm, abort, tmo_evt, smp_ok, terr_d;

  assign arm = cmd_valid && (cmd_op == 2'd1 || cmd_op == 2'd2);
  assign abort = cmd_valid && cmd_op == 2'd3;
  assign tmo_evt = state_q == RUN && !ev_end && !abort && rc_q == TIMEOUT;
  assign smp_ok = state_q == SAMPLE && !abort_pend_q && !tmo_q;
  assign pc_start = state_q == START;
  assign pc_stop = state_q == STOP;
  assign busy = state_q != IDLE;
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign sample_done = done_q;

  // A clear coinciding with a sample yields the cleared values with that sample applied.
  always_comb begin
    last_d = smp_ok ? pc_value : (clr_stats ? '0 : last_q);
    min_b = clr_stats ? '1 : min_q;
    min_d = (smp_ok && pc_value < min_b) ? pc_value : min_b;
    max_b = clr_stats ? '0 : max_q;
    max_d = (smp_ok && pc_value > max_b) ? pc_value : max_b;
    sum_b = clr_stats ? '0 : sum_q;
    sum_x = {1'b0, sum_b} + {{(SUM_W-31){1'b0}}, pc_value};
    sum_d = !smp_ok ? sum_b : (sum_x[SUM_W] ? '1 : sum_x[SUM_W-1:0]);
    cnt_b = clr_stats ? '0 : cnt_q;
    cnt_d = (smp_ok && cnt_b != '1) ? cnt_b + 32'd1 : cnt_b;
    tmo_b = clr_stats ? '0 : tmo_cnt_q;
    tmo_d = (tmo_evt && tmo_b != '1) ? tmo_b + 32'd1 : tmo_b;
    terr_d = tmo_evt || (!clr_stats && terr_q);
  end

  always_comb begin
    rd_d = tmo_cnt_q;
    case (rd_addr)
      3'd0: rd_d = last_q;
      3'd1: rd_d = min_q;
      3'd2: rd_d = max_q;
      3'd3: rd_d = sum_q[31:0];
      3'd4: rd_d = 32'(shadow_q);
      3'd5: rd_d = cnt_q;
      3'd6: rd_d = {26'b0, mode_q, terr_q, state_q, busy};
      default: rd_d = tmo_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= 1'b0;
      abort_pend_q <= 1'b0;
      tmo_q <= 1'b0;
      rc_q <= '0;
      last_q <= '0;
      min_q <= '1;
      max_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      tmo_cnt_q <= '0;
      terr_q <= 1'b0;
      done_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
      shadow_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (arm) begin
          state_q <= ARMED;
          mode_q <= cmd_op == 2'd2;
        end
        ARMED: if (abort) state_q <= IDLE;
        else begin
          if (arm) mode_q <= cmd_op == 2'd2;
          if (ev_begin) state_q <= START;
        end
        START: begin
          state_q <= RUN;
          rc_q <= 32'd1;
          if (abort) abort_pend_q <= 1'b1;
        end
        RUN: begin
          rc_q <= rc_q + 32'd1;
          if (ev_end || abort) begin
            state_q <= STOP;
            if (abort) abort_pend_q <= 1'b1;
          end else if (rc_q == TIMEOUT) begin
            state_q <= STOP;
            tmo_q <= 1'b1;
          end
        end
        STOP: state_q <= SAMPLE;
        SAMPLE: begin
          state_q <= (abort_pend_q || !mode_q) ? IDLE : ARMED;
          abort_pend_q <= 1'b0;
          tmo_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
      last_q <= last_d;
      min_q <= min_d;
      max_q <= max_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      tmo_cnt_q <= tmo_d;
      terr_q <= terr_d;
      done_q <= smp_ok;
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_d;
        if (rd_addr == 3'd3) shadow_q <= sum_q[SUM_W-1:32];
      end
    end
  end
endmodule

// File: tb/tb_perf_window_ctrl.sv
// tb_perf_window_ctrl: randomized windows against a statistics model; two instances
// (48-bit and 33-bit sum) share stimulus so sum saturation is reachable in few samples.
module tb_perf_window_ctrl;
  localparam int T = 320;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, clr_stats = 0, ev_begin = 0, ev_end = 0, rd_en = 0;
  logic [1:0] cmd_op = 0;
  logic [2:0] rd_addr = 0;
  logic [31:0] pc_value, cnt, ovr_v = 0;
  logic cnt_en, ovr_en = 0;
  logic pc_start_a, pc_stop_a, rd_valid_a, busy_a, sample_done_a;
  logic pc_start_b, pc_stop_b, rd_valid_b, busy_b, sample_done_b;
  logic [31:0] rd_data_a, rd_data_b;
  int cyc = 0, checks = 0, errors = 0;

  typedef struct {logic [2:0] a; logic [31:0] e1; logic [31:0] e2;} rd_t;
  int q_start[$], q_stop[$], q_done[$];
  rd_t q_rd[$];

  logic [31:0] m_last, m_min, m_max, m_cnt, m_tmo, sh48, sh33;
  logic [63:0] m_sum;
  logic m_terr, m_mode, m_armed;

  perf_window_ctrl #(.SUM_W(48), .TIMEOUT(T)) dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .clr_stats(clr_stats),
    .ev_begin(ev_begin), .ev_end(ev_end), .pc_start(pc_start_a), .pc_stop(pc_stop_a),
    .pc_value(pc_value), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .busy(busy_a), .sample_done(sample_done_a));
  perf_window_ctrl #(.SUM_W(33), .TIMEOUT(T)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .clr_stats(clr_stats),
    .ev_begin(ev_begin), .ev_end(ev_end), .pc_start(pc_start_b), .pc_stop(pc_stop_b),
    .pc_value(pc_value), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .busy(busy_b), .sample_done(sample_done_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External counter: start clears and enables, stop freezes.
  always @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= 0;
      cnt_en <= 0;
    end else if (pc_start_a) begin
      cnt <= 0;
      cnt_en <= 1;
    end else if (pc_stop_a) cnt_en <= 0;
    else if (cnt_en) cnt <= cnt + 1;
  assign pc_value = ovr_en ? ovr_v : cnt;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic m_clear;
    m_last = 0; m_min = '1; m_max = 0; m_sum = 0; m_cnt = 0; m_tmo = 0; m_terr = 0;
  endtask

  task automatic m_reset;
    m_clear();
    m_mode = 0; m_armed = 0; sh48 = 0; sh33 = 0;
  endtask

  function automatic logic [63:0] sat(input int w);
    logic [63:0] mx;
    mx = (64'd1 << w) - 1;
    return (m_sum > mx) ? mx : m_sum;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] a, input int w);
    logic [63:0] s;
    s = sat(w);
    case (a)
      3'd0: return m_last;
      3'd1: return m_min;
      3'd2: return m_max;
      3'd3: return s[31:0];
      3'd4: return (w == 48) ? sh48 : sh33;
      3'd5: return m_cnt;
      3'd6: return {26'b0, m_mode, m_terr, m_armed ? 3'd1 : 3'd0, m_armed};
      default: return m_tmo;
    endcase
  endfunction

  task automatic rd(input logic [2:0] a);
    rd_t r;
    r.a = a; r.e1 = exp_rd(a, 48); r.e2 = exp_rd(a, 33);
    q_rd.push_back(r);
    if (a == 3'd3) begin
      sh48 = 32'(sat(48) >> 32);
      sh33 = 32'(sat(33) >> 32);
    end
    rd_en = 1; rd_addr = a;
    step();
    rd_en = 0;
  endtask

  task automatic cmd(input logic [1:0] op);
    cmd_valid = 1; cmd_op = op;
    step();
    cmd_valid = 0;
    if (op == 2'd1 || op == 2'd2) begin
      m_mode = op == 2'd2;
      m_armed = 1;
    end else if (op == 2'd3) m_armed = 0;
  endtask

  task automatic clr;
    clr_stats = 1;
    step();
    clr_stats = 0;
    m_clear();
  endtask

  // kind: 0 normal end, 1 timeout, 2 abort in RUN, 3 abort in START then end
  task automatic window(input int kind, input int len, input bit c_at_s, input bit ovr, input logic [31:0] ov);
    int b, e, sc, c;
    logic [31:0] v;
    if ($urandom_range(0, 3) == 0) begin
      ev_end = 1;
      step();
      ev_end = 0;
    end
    b = cyc; e = b + 1 + len; sc = (kind == 1) ? b + 2 + T : e + 1;
    q_start.push_back(b + 1);
    q_stop.push_back(sc);
    if (kind == 0) q_done.push_back(sc + 2);
    ovr_en = ovr; ovr_v = ov;
    ev_begin = 1;
    step();
    while (cyc <= sc + 1) begin
      c = cyc;
      ev_end = ((kind == 0 || kind == 3) && c == e) || (c == b + 1 && $urandom_range(0, 1) == 1);
      cmd_valid = (kind == 2 && c == e) || (kind == 3 && c == b + 1);
      cmd_op = 2'd3;
      clr_stats = c_at_s && c == sc + 1;
      ev_begin = c > b + 1 && c < sc && $urandom_range(0, 7) == 0;
      step();
    end
    ev_end = 0; cmd_valid = 0; clr_stats = 0; ev_begin = 0; ovr_en = 0;
    v = ovr ? ov : 32'(len);
    if (kind == 1) begin
      m_terr = 1;
      if (m_tmo != '1) m_tmo++;
    end
    if (c_at_s) m_clear();
    if (kind == 0) begin
      m_last = v;
      if (v < m_min) m_min = v;
      if (v > m_max) m_max = v;
      m_sum += 64'(v);
      if (m_cnt != '1) m_cnt++;
    end
    m_armed = (kind == 0 || kind == 1) && m_mode;
  endtask

  initial begin
    m_reset();
    fork
      begin
        repeat (3) step();
        rst = 0;
        chk("reset_outputs", {pc_start_a, pc_stop_a, busy_a, sample_done_a, rd_valid_a, rd_data_a}, 0);
        for (int i = 0; i < 8; i++) rd(3'(i));
        cmd(2'd1);
        window(0, 10, 0, 0, 0);
        for (int i = 0; i < 8; i++) rd(3'(i));
        clr();
        cmd(2'd2);
        window(0, 5, 0, 0, 0);
        window(0, 1, 0, 0, 0);
        window(0, 300, 0, 0, 0);
        for (int i = 0; i < 8; i++) rd(3'(i));
        cmd(2'd1);
        rd(6);
        cmd(2'd3);
        rd(6);
        cmd(2'd3);
        rd(6);
        cmd(2'd1);
        window(1, 0, 0, 0, 0);
        rd(7); rd(6); rd(5); rd(3);
        cmd(2'd1);
        window(2, 7, 0, 0, 0);
        rd(6); rd(5);
        cmd(2'd1);
        window(0, 7, 1, 0, 0);
        rd(5); rd(1); rd(2); rd(3); rd(6);
        cmd(2'd2);
        for (int i = 0; i < 3; i++) window(0, 4, 0, 1, 32'hFFFF_FFF0);
        window(0, 4, 0, 1, 32'h20);
        rd(3); rd(4); rd(5); rd(2);
        cmd(2'd3);
        for (int it = 0; it < 150; it++) begin
          int r, k, kind, len;
          r = $urandom_range(0, 9);
          if (r == 0) rd(3'($urandom_range(0, 7)));
          else if (r == 1) clr();
          else if (r == 2) cmd(2'($urandom_range(0, 3)));
          else if (r == 9) begin
            rd(3); rd(4);
          end else begin
            if (!m_armed) cmd(2'($urandom_range(1, 2)));
            k = $urandom_range(0, 9);
            kind = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 3 : 0;
            len = (kind == 0 && $urandom_range(0, 9) == 0) ? T : $urandom_range(1, 30);
            window(kind, len, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom);
            rd(3'($urandom_range(0, 7)));
          end
        end
        if (!m_armed) cmd(2'd2);
        q_start.push_back(cyc + 1);
        ev_begin = 1;
        step();
        ev_begin = 0;
        repeat (6) step();
        #2 rst = 1;
        #1 chk("async_reset", {pc_start_a, pc_stop_a, busy_a, sample_done_a, rd_valid_a, rd_data_a}, 0);
        step(); step();
        rst = 0;
        m_reset();
        for (int i = 0; i < 8; i++) rd(3'(i));
        repeat (5) step();
      end
      forever begin
        @(negedge clk);
        chk("dut_b_sync", {pc_start_b, pc_stop_b, sample_done_b, rd_valid_b, busy_b},
            {pc_start_a, pc_stop_a, sample_done_a, rd_valid_a, busy_a});
        if (pc_start_a) begin
          chk("pc_start_expected", q_start.size() != 0, 1);
          if (q_start.size() != 0) chk("pc_start_cycle", cyc, q_start.pop_front());
        end
        if (pc_stop_a) begin
          chk("pc_stop_expected", q_stop.size() != 0, 1);
          if (q_stop.size() != 0) chk("pc_stop_cycle", cyc, q_stop.pop_front());
        end
        if (sample_done_a) begin
          chk("sample_done_expected", q_done.size() != 0, 1);
          if (q_done.size() != 0) chk("sample_done_cycle", cyc, q_done.pop_front());
        end
        if (rd_valid_a) begin
          chk("rd_expected", q_rd.size() != 0, 1);
          if (q_rd.size() != 0) begin
            rd_t r;
            r = q_rd.pop_front();
            chk($sformatf("rd48_addr%0d", r.a), rd_data_a, r.e1);
            chk($sformatf("rd33_addr%0d", r.a), rd_data_b, r.e2);
          end
        end
      end
    join_any
    chk("pending_expectations", q_start.size() + q_stop.size() + q_done.size() + q_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
